// File: rtl/tetris_pkg.sv
// Shared palette, fixed colours and row-clear FSM states for the Tetris board renderer.
package tetris_pkg;

  localparam logic [11:0] GREY  = 12'h333;
  localparam logic [11:0] BLACK = 12'h000;

  typedef enum logic [1:0] {IDLE, SHIFT, ZERO} clr_state_e;

  // Index 0 is the empty cell; anything past the 7 defined pieces renders as grey-white.
  function automatic logic [11:0] color_lut(input logic [31:0] idx);
    logic [11:0] c;
    case (idx)
      32'd0:   c = BLACK;
      32'd1:   c = 12'hAAA;
      32'd2:   c = 12'hF00;
      32'd3:   c = 12'h0F0;
      32'd4:   c = 12'h00F;
      32'd5:   c = 12'hFF0;
      32'd6:   c = 12'hF0F;
      32'd7:   c = 12'h0FF;
      default: c = 12'hAAA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tetris_cell_locate.sv
// Stage 1: maps the current pixel to a board cell via constant compare chains and registers
// the cell coordinates, lit flag and frame flag.
module tetris_cell_locate
  import tetris_pkg::*;
#(
  parameter int COLS  = 10,
  parameter int ROWS  = 12,
  parameter int CELL  = 27,
  parameter int GAP   = 1,
  parameter int ORG_X = 100,
  parameter int ORG_Y = 78,
  parameter int RW    = 4,
  parameter int CLW   = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [9:0]     hCount,
  input  logic [9:0]     vCount,
  output logic [RW-1:0]  row,
  output logic [CLW-1:0] col,
  output logic           lit,
  output logic           in_board
);

  logic [10:0]    hx, vy;
  logic [COLS:0]  ge_x;
  logic [ROWS:0]  ge_y;
  logic [COLS-1:0] lit_x;
  logic [ROWS-1:0] lit_y;
  logic           frame_x, frame_y;
  logic [RW-1:0]  row_next, row_reg;
  logic [CLW-1:0] col_next, col_reg;
  logic           lit_reg, in_board_reg;

  assign hx = {1'b0, hCount};
  assign vy = {1'b0, vCount};

  // ge_*[k] = pixel is at or past the left/top edge of cell k; index COLS/ROWS is the far edge.
  generate
    for (genvar gi = 0; gi <= COLS; gi++) begin : g_xb
      assign ge_x[gi] = hx >= 11'(ORG_X + gi * CELL);
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_xl
      assign lit_x[gi] = ge_x[gi] && (hx < 11'(ORG_X + gi * CELL + CELL - GAP));
    end
    for (genvar gi = 0; gi <= ROWS; gi++) begin : g_yb
      assign ge_y[gi] = vy >= 11'(ORG_Y + gi * CELL);
    end
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_yl
      assign lit_y[gi] = ge_y[gi] && (vy < 11'(ORG_Y + gi * CELL + CELL - GAP));
    end
  endgenerate

  assign frame_x = ((ORG_X == 0) || (hx >= 11'(ORG_X - 1))) && (hx <= 11'(ORG_X + COLS * CELL));
  assign frame_y = ((ORG_Y == 0) || (vy >= 11'(ORG_Y - 1))) && (vy <= 11'(ORG_Y + ROWS * CELL));

  // Outside the grid the coordinates collapse to 0 so the board lookup stays in range.
  always_comb begin
    col_next = '0;
    for (int c = 1; c < COLS; c++)
      if (ge_x[c] && !ge_x[COLS]) col_next = CLW'(c);
    row_next = '0;
    for (int r = 1; r < ROWS; r++)
      if (ge_y[r] && !ge_y[ROWS]) row_next = RW'(r);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_reg      <= '0;
      col_reg      <= '0;
      lit_reg      <= 1'b0;
      in_board_reg <= 1'b0;
    end else begin
      row_reg      <= row_next;
      col_reg      <= col_next;
      lit_reg      <= (|lit_x) && (|lit_y);
      in_board_reg <= frame_x && frame_y;
    end
  end

  assign row      = row_reg;
  assign col      = col_reg;
  assign lit      = lit_reg;
  assign in_board = in_board_reg;

endmodule

// File: rtl/tetris_board_renderer.sv
// Settled-board store with row-clear shifting, falling-piece overlay and a two-stage
// pixel pipeline producing registered 12-bit RGB.
module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int COLS  = 10,
  parameter int ROWS  = 12,
  parameter int CELL  = 27,
  parameter int GAP   = 1,
  parameter int ORG_X = 100,
  parameter int ORG_Y = 78,
  parameter int CW    = 3,
  localparam int RW   = $clog2(ROWS),
  localparam int CLW  = $clog2(COLS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [CLW-1:0]   wr_col,
  input  logic [CW-1:0]    wr_color,
  input  logic             clr_req,
  input  logic [RW-1:0]    clr_row,
  input  logic             piece_valid,
  input  logic [4*RW-1:0]  piece_row,
  input  logic [4*CLW-1:0] piece_col,
  input  logic [CW-1:0]    piece_color,
  output logic             busy,
  output logic [ROWS-1:0]  row_full,
  output logic [11:0]      rgb
);

  logic [CW-1:0]   board_reg [ROWS][COLS];
  clr_state_e      state_reg, state_next;
  logic [RW-1:0]   r_reg, r_next;
  logic            clr_accept, shift_en, zero_en, wr_ok;
  logic [ROWS-1:0] full_next, row_full_reg;
  logic [RW-1:0]   loc_row;
  logic [CLW-1:0]  loc_col;
  logic            loc_lit, loc_in_board;
  logic [3:0]      hit_vec;
  logic [CW-1:0]   cell_val;
  logic [11:0]     rgb_next, rgb_reg;

  tetris_cell_locate #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .GAP(GAP),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .RW(RW), .CLW(CLW)
  ) u_locate (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .hCount  (hCount),
    .vCount  (vCount),
    .row     (loc_row),
    .col     (loc_col),
    .lit     (loc_lit),
    .in_board(loc_in_board)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    clr_accept = 1'b0;
    shift_en   = 1'b0;
    zero_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req && (32'(clr_row) < ROWS)) begin
          clr_accept = 1'b1;
          r_next     = clr_row;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_reg == '0) begin
          state_next = ZERO;
        end else begin
          shift_en = 1'b1;
          r_next   = r_reg - RW'(1);
        end
      end
      ZERO: begin
        zero_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg != IDLE);
  // A clear accepted this cycle takes precedence over a coincident write.
  assign wr_ok = wr_en && (state_reg == IDLE) && !clr_accept &&
                 (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board_reg[r][c] <= '0;
    end else begin
      if (wr_ok)
        board_reg[wr_row][wr_col] <= wr_color;
      if (shift_en)
        for (int c = 0; c < COLS; c++)
          board_reg[r_reg][c] <= board_reg[r_reg - RW'(1)][c];
      if (zero_en)
        for (int c = 0; c < COLS; c++)
          board_reg[0][c] <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_full
      logic [COLS-1:0] nz;
      for (genvar gj = 0; gj < COLS; gj++) begin : g_nz
        assign nz[gj] = |board_reg[gi][gj];
      end
      assign full_next[gi] = &nz;
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign hit_vec[gi] = (piece_row[gi*RW +: RW] == loc_row) &&
                           (piece_col[gi*CLW +: CLW] == loc_col);
    end
  endgenerate

  assign cell_val = board_reg[loc_row][loc_col];

  always_comb begin
    rgb_next = BLACK;
    if (piece_valid && loc_lit && (|hit_vec))
      rgb_next = color_lut(32'(piece_color));
    else if (loc_lit && (cell_val != '0))
      rgb_next = color_lut(32'(cell_val));
    else if (loc_in_board)
      rgb_next = GREY;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_full_reg <= '0;
      rgb_reg      <= '0;
    end else begin
      row_full_reg <= full_next;
      rgb_reg      <= rgb_next;
    end
  end

  assign row_full = row_full_reg;
  assign rgb      = rgb_reg;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Self-checking bench: fixed vector table, randomized writes/pixels against a cell-level
// board model, and hand-written row-clear and reset-abort sequences.
module tb_tetris_board_renderer;

  localparam int COLS = 10, ROWS = 12, CELL = 27, GAP = 1, ORG_X = 100, ORG_Y = 78, CW = 3;
  localparam int RW = 4, CLW = 4;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic [9:0]       hCount, vCount;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [CLW-1:0]   wr_col;
  logic [CW-1:0]    wr_color;
  logic             clr_req;
  logic [RW-1:0]    clr_row;
  logic             piece_valid;
  logic [4*RW-1:0]  piece_row;
  logic [4*CLW-1:0] piece_col;
  logic [CW-1:0]    piece_color;
  logic             busy;
  logic [ROWS-1:0]  row_full;
  logic [11:0]      rgb;

  tetris_board_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .hCount(hCount), .vCount(vCount),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color),
    .clr_req(clr_req), .clr_row(clr_row),
    .piece_valid(piece_valid), .piece_row(piece_row), .piece_col(piece_col),
    .piece_color(piece_color),
    .busy(busy), .row_full(row_full), .rgb(rgb)
  );

  always #5 Clk = ~Clk;

  int model_board [ROWS][COLS];
  int pr [4];
  int pc [4];
  int pcolor;
  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    bit          do_wr;
    int          wr_r, wr_c, wr_v;
    int          h, v;
    bit          pv;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [16];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("  ok   %-16s %h", name, act);
    end else begin
      $display("FAIL %-16s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pal(input int i);
    case (i)
      0: return 12'h000;
      1: return 12'hAAA;
      2: return 12'hF00;
      3: return 12'h0F0;
      4: return 12'h00F;
      5: return 12'hFF0;
      6: return 12'hF0F;
      7: return 12'h0FF;
      default: return 12'hAAA;
    endcase
  endfunction

  // Reference pixel: geometry by division/modulo on the board origin.
  function automatic logic [11:0] ref_pixel(input int h, input int v);
    bit inb, lit, hit;
    int c, r;
    inb = (h >= ORG_X - 1) && (h <= ORG_X + COLS * CELL) &&
          (v >= ORG_Y - 1) && (v <= ORG_Y + ROWS * CELL);
    lit = 0; hit = 0; c = 0; r = 0;
    if (h >= ORG_X && h < ORG_X + COLS * CELL && v >= ORG_Y && v < ORG_Y + ROWS * CELL) begin
      c = (h - ORG_X) / CELL;
      r = (v - ORG_Y) / CELL;
      lit = ((h - ORG_X) % CELL < CELL - GAP) && ((v - ORG_Y) % CELL < CELL - GAP);
    end
    for (int k = 0; k < 4; k++)
      if (pr[k] == r && pc[k] == c) hit = 1;
    if (piece_valid && lit && hit) return pal(pcolor);
    if (lit && model_board[r][c] != 0) return pal(model_board[r][c]);
    if (inb) return 12'h333;
    return 12'h000;
  endfunction

  function automatic logic [ROWS-1:0] model_full();
    logic [ROWS-1:0] f;
    for (int r = 0; r < ROWS; r++) begin
      f[r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (model_board[r][c] == 0) f[r] = 1'b0;
    end
    return f;
  endfunction

  task automatic model_clear(input int row);
    for (int r = row; r > 0; r--)
      for (int c = 0; c < COLS; c++) model_board[r][c] = model_board[r-1][c];
    for (int c = 0; c < COLS; c++) model_board[0][c] = 0;
  endtask

  task automatic apply_piece();
    for (int k = 0; k < 4; k++) begin
      piece_row[k*RW +: RW]   = 4'(pr[k]);
      piece_col[k*CLW +: CLW] = 4'(pc[k]);
    end
    piece_color = 3'(pcolor);
  endtask

  task automatic do_write(input int r, input int c, input int col);
    wr_en = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_color = 3'(col);
    tick();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) model_board[r][c] = col;
  endtask

  task automatic check_pixel(input string name, input int h, input int v);
    hCount = 10'(h); vCount = 10'(v);
    tick(); tick();
    check(name, 32'(rgb), 32'(ref_pixel(h, v)));
  endtask

  task automatic sweep(input string tag);
    piece_valid = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check_pixel($sformatf("%s_r%0dc%0d", tag, r, c),
                    ORG_X + c * CELL + int'($urandom_range(0, CELL - GAP - 1)),
                    ORG_Y + r * CELL + int'($urandom_range(0, CELL - GAP - 1)));
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog    got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [ROWS-1:0] prev_full;
    Reset_n = 1'b0; hCount = '0; vCount = '0; wr_en = 1'b0; wr_row = '0; wr_col = '0;
    wr_color = '0; clr_req = 1'b0; clr_row = '0; piece_valid = 1'b0;
    pr = '{0, 0, 1, 5}; pc = '{0, 1, 0, 5}; pcolor = 4;
    apply_piece();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_board[r][c] = 0;

    vecs[0]  = '{0, 0, 0, 0, 105, 83, 0, 12'h333};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 12'h000};
    vecs[2]  = '{0, 0, 0, 0, 99, 77, 0, 12'h333};
    vecs[3]  = '{0, 0, 0, 0, 370, 402, 0, 12'h333};
    vecs[4]  = '{0, 0, 0, 0, 371, 100, 0, 12'h000};
    vecs[5]  = '{0, 0, 0, 0, 98, 100, 0, 12'h000};
    vecs[6]  = '{1, 3, 4, 2, 211, 162, 0, 12'hF00};
    vecs[7]  = '{0, 0, 0, 0, 234, 162, 0, 12'h333};
    vecs[8]  = '{0, 0, 0, 0, 233, 162, 0, 12'hF00};
    vecs[9]  = '{0, 0, 0, 0, 211, 185, 0, 12'h333};
    vecs[10] = '{1, 0, 0, 1, 103, 81, 1, 12'h00F};
    vecs[11] = '{0, 0, 0, 0, 103, 81, 0, 12'hAAA};
    vecs[12] = '{0, 0, 0, 0, 100, 78, 0, 12'hAAA};
    vecs[13] = '{0, 0, 0, 0, 130, 81, 1, 12'h00F};
    vecs[14] = '{0, 0, 0, 0, 126, 81, 1, 12'h333};
    vecs[15] = '{0, 0, 0, 0, 130, 81, 0, 12'h333};

    repeat (2) tick();
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_full", 32'(row_full), 32'h0);
    #2 Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].wr_r, vecs[i].wr_c, vecs[i].wr_v);
      piece_valid = vecs[i].pv;
      hCount = 10'(vecs[i].h); vCount = 10'(vecs[i].v);
      tick(); tick();
      check($sformatf("vec%0d", i), 32'(rgb), 32'(vecs[i].exp));
    end

    for (int i = 0; i < 60; i++) begin
      do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      tick();
      check($sformatf("rand_full%0d", i), 32'(row_full), 32'(model_full()));
    end

    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 4; k++) begin
        pr[k] = int'($urandom_range(0, 12));
        pc[k] = int'($urandom_range(0, 10));
      end
      pcolor = int'($urandom_range(0, 7));
      apply_piece();
      piece_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        check_pixel($sformatf("rand_px%0d", i), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      else
        check_pixel($sformatf("rand_px%0d", i), int'($urandom_range(90, 380)), int'($urandom_range(65, 415)));
    end

    // Row 10 gets distinct non-full contents; row 11 is then filled.
    for (int c = 0; c < COLS; c++) do_write(10, c, (c % 4 == 3) ? 0 : 1 + c % 7);
    for (int c = 0; c < COLS - 1; c++) do_write(11, c, 1);
    tick();
    prev_full = model_full();
    do_write(11, COLS - 1, 1);
    check("full_lag", 32'(row_full), 32'(prev_full));
    tick();
    check("full_row11", 32'(row_full[11]), 32'h1);
    check("full_vec", 32'(row_full), 32'(model_full()));

    // Clear row 11 with a coincident write, then writes and clears held during busy.
    clr_req = 1'b1; clr_row = 4'd11;
    wr_en = 1'b1; wr_row = 4'd2; wr_col = 4'd2; wr_color = 3'd5;
    tick();
    model_clear(11);
    wr_row = 4'd0; wr_col = 4'd5; wr_color = 3'd7;
    count_busy(cnt);
    clr_req = 1'b0; wr_en = 1'b0;
    check("busy_cycles11", 32'(cnt), 32'd13);
    tick();
    check("full_after_clr", 32'(row_full), 32'(model_full()));
    sweep("clr11");

    clr_req = 1'b1; clr_row = 4'd13;
    tick();
    clr_req = 1'b0;
    check("clr_oor_busy", 32'(busy), 32'h0);

    clr_req = 1'b1; clr_row = 4'd0;
    tick();
    clr_req = 1'b0;
    model_clear(0);
    count_busy(cnt);
    check("busy_cycles0", 32'(cnt), 32'd2);
    sweep("clr0");

    // Abort a clear with reset during its 5th shift cycle.
    for (int c = 0; c < COLS; c++) do_write(5, c, 3);
    hCount = 10'd105; vCount = 10'd83;
    clr_req = 1'b1; clr_row = 4'd11;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    check("pre_abort_busy", 32'(busy), 32'h1);
    check("pre_abort_full", 32'(row_full[5]), 32'h1);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rgb", 32'(rgb), 32'h0);
    check("abort_full", 32'(row_full), 32'h0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_board[r][c] = 0;
    tick();
    #2 Reset_n = 1'b1;
    tick();
    check("post_abort_busy", 32'(busy), 32'h0);
    sweep("abort");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
